// File: rtl/game_controller_if.sv
// Player/screen-side signal bundle for the two-player door game controller.
// The controller connects through the slave modport; the stimulus side
// (players, start button, screen drawer) connects through the master modport.
interface game_controller_if;
    logic       start;
    logic       p1_valid;
    logic [1:0] p1_choice;
    logic       p2_valid;
    logic [1:0] p2_choice;
    logic [1:0] correct_door;
    logic [1:0] p1_lives;
    logic [1:0] p2_lives;
    logic       time_up;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        output start, p1_valid, p1_choice, p2_valid, p2_choice,
        input  correct_door, p1_lives, p2_lives, time_up, game_over, winner
    );

    modport slave (
        input  start, p1_valid, p1_choice, p2_valid, p2_choice,
        output correct_door, p1_lives, p2_lives, time_up, game_over, winner
    );
endinterface

// File: rtl/game_controller.sv
// Two-player "pick the door" game controller.
// Each round a door is drawn from a free-running LFSR, both players get a timed
// window to lock in one choice, the correct door is revealed for a fixed time,
// then wrong or missing answers cost a life. The game ends when a player runs
// out of lives; start replays from the game-over screen.
module game_controller #(
    parameter int ROUND_CYCLES  = 250000000,
    parameter int REVEAL_CYCLES = 75000000
) (
    input  logic        clk,
    input  logic        reset,
    game_controller_if.slave bus
);

    localparam int MAX_CYCLES = (ROUND_CYCLES > REVEAL_CYCLES) ? ROUND_CYCLES : REVEAL_CYCLES;
    // Keep at least one timer bit so single-cycle windows still elaborate.
    localparam int TIMER_W = ($clog2(MAX_CYCLES) < 1) ? 1 : $clog2(MAX_CYCLES);
    localparam logic [TIMER_W-1:0] ROUND_LOAD  = TIMER_W'(ROUND_CYCLES - 1);
    localparam logic [TIMER_W-1:0] REVEAL_LOAD = TIMER_W'(REVEAL_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, PICK, CHOOSE, REVEAL, SCORE, OVER} state_t;

    state_t               state, state_next;
    logic [TIMER_W-1:0]   timer, timer_next;
    logic [7:0]           lfsr;
    logic [1:0]           correct_door;
    logic [1:0]           p1_lives, p2_lives;
    logic [1:0]           p1_sel, p2_sel;
    logic                 p1_latched, p2_latched;
    logic                 time_up, game_over;
    logic [1:0]           winner;

    logic                 p1_take, p2_take;
    logic                 p1_miss, p2_miss;
    logic [1:0]           p1_scored, p2_scored;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        // NOTE: every clocked assignment is non-blocking so all registers
        // sample pre-edge values regardless of block ordering.
        else       state <= state_next;
    end

    // Next-state, timer and scoring decisions.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a value held (no latches).
        state_next = state;
        timer_next = timer;
        p1_take    = 1'b0;
        p2_take    = 1'b0;
        p1_miss    = !p1_latched || (p1_sel != correct_door);
        p2_miss    = !p2_latched || (p2_sel != correct_door);
        p1_scored  = (p1_miss && p1_lives != 2'd0) ? p1_lives - 2'd1 : p1_lives;
        p2_scored  = (p2_miss && p2_lives != 2'd0) ? p2_lives - 2'd1 : p2_lives;

        case (state)
            IDLE: if (bus.start) state_next = PICK;
            PICK: begin
                timer_next = ROUND_LOAD;
                state_next = CHOOSE;
            end
            CHOOSE: begin
                p1_take = bus.p1_valid && !p1_latched;
                p2_take = bus.p2_valid && !p2_latched;
                // A strobe arriving this cycle already counts towards "both chose".
                if (timer == '0 ||
                    ((p1_latched || bus.p1_valid) && (p2_latched || bus.p2_valid))) begin
                    timer_next = REVEAL_LOAD;
                    state_next = REVEAL;
                end else begin
                    timer_next = timer - TIMER_W'(1);
                end
            end
            REVEAL: begin
                if (timer == '0) state_next = SCORE;
                else             timer_next = timer - TIMER_W'(1);
            end
            SCORE: state_next = (p1_scored == 2'd0 || p2_scored == 2'd0) ? OVER : PICK;
            OVER:  if (bus.start) state_next = PICK;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: LFSR, timer, door draw, choice latches, lives and result flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr         <= 8'h01;
            timer        <= '0;
            correct_door <= 2'd0;
            p1_lives     <= 2'd3;
            p2_lives     <= 2'd3;
            p1_sel       <= 2'd0;
            p2_sel       <= 2'd0;
            p1_latched   <= 1'b0;
            p2_latched   <= 1'b0;
            time_up      <= 1'b0;
            game_over    <= 1'b0;
            winner       <= 2'd0;
        end else begin
            // Taps 8,6,5,4: maximal length, so the all-zero state is unreachable.
            lfsr    <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            timer   <= timer_next;
            time_up <= (state_next == REVEAL);

            case (state)
                PICK: begin
                    correct_door <= lfsr[1:0];
                    p1_sel       <= 2'd0;
                    p2_sel       <= 2'd0;
                    p1_latched   <= 1'b0;
                    p2_latched   <= 1'b0;
                end
                CHOOSE: begin
                    if (p1_take) begin
                        p1_latched <= 1'b1;
                        p1_sel     <= bus.p1_choice;
                    end
                    if (p2_take) begin
                        p2_latched <= 1'b1;
                        p2_sel     <= bus.p2_choice;
                    end
                end
                SCORE: begin
                    p1_lives <= p1_scored;
                    p2_lives <= p2_scored;
                    if (state_next == OVER) begin
                        game_over <= 1'b1;
                        // Bit 1 set means P2 won (P1 out), bit 0 means P1 won.
                        winner    <= {p1_scored == 2'd0, p2_scored == 2'd0};
                    end
                end
                OVER: begin
                    if (bus.start) begin
                        p1_lives  <= 2'd3;
                        p2_lives  <= 2'd3;
                        game_over <= 1'b0;
                        winner    <= 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.correct_door = correct_door;
    assign bus.p1_lives     = p1_lives;
    assign bus.p2_lives     = p2_lives;
    assign bus.time_up      = time_up;
    assign bus.game_over    = game_over;
    assign bus.winner       = winner;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with short windows (8 choose, 4 reveal).
// The expected door comes from an independent model of the 8-bit LFSR.
module tb_game_controller;

    localparam int ROUND  = 8;
    localparam int REVEAL = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    game_controller_if bus ();

    game_controller #(
        .ROUND_CYCLES (ROUND),
        .REVEAL_CYCLES(REVEAL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] lfsr_m;
    logic [1:0] exp_door;

    // Reference LFSR: seed 01, taps 8,6,5,4, advancing every clock.
    always @(posedge clk or posedge reset) begin
        if (reset) lfsr_m <= 8'h01;
        else       lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.p1_valid  = 1'b0;
        bus.p1_choice = 2'd0;
        bus.p2_valid  = 1'b0;
        bus.p2_choice = 2'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // From IDLE/OVER: pulse start, record the door drawn in PICK, stop in first CHOOSE cycle.
    task automatic begin_game();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_door = lfsr_m[1:0];
        tick();
    endtask

    // Counts remaining CHOOSE cycles (time_up low) then REVEAL cycles; ends in SCORE.
    task automatic run_to_score(output int choose_cnt, output int reveal_cnt);
        choose_cnt = 0;
        reveal_cnt = 0;
        while (bus.time_up === 1'b0 && choose_cnt < 100) begin
            choose_cnt++;
            tick();
        end
        while (bus.time_up === 1'b1 && reveal_cnt < 100) begin
            reveal_cnt++;
            tick();
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        checks++; if (bus.correct_door !== 2'd0) begin errors++; $display("FAIL reset_door: got %0d want 0", bus.correct_door); end
        checks++; if (bus.p1_lives !== 2'd3) begin errors++; $display("FAIL reset_p1_lives: got %0d want 3", bus.p1_lives); end
        checks++; if (bus.p2_lives !== 2'd3) begin errors++; $display("FAIL reset_p2_lives: got %0d want 3", bus.p2_lives); end
        checks++; if (bus.time_up !== 1'b0) begin errors++; $display("FAIL reset_time_up: got %0d want 0", bus.time_up); end
        checks++; if (bus.game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %0d want 0", bus.game_over); end
        checks++; if (bus.winner !== 2'd0) begin errors++; $display("FAIL reset_winner: got %0d want 0", bus.winner); end
        reset = 1'b0;
    endtask

    task automatic test_timeout();
        int c, r;
        do_reset();
        begin_game();
        checks++; if (bus.correct_door !== exp_door) begin errors++; $display("FAIL timeout_door: got %0d want %0d", bus.correct_door, exp_door); end
        run_to_score(c, r);
        checks++; if (c != ROUND) begin errors++; $display("FAIL timeout_choose_len: got %0d want %0d", c, ROUND); end
        checks++; if (r != REVEAL) begin errors++; $display("FAIL timeout_reveal_len: got %0d want %0d", r, REVEAL); end
        tick();
        checks++; if (bus.p1_lives !== 2'd2) begin errors++; $display("FAIL timeout_p1_lives: got %0d want 2", bus.p1_lives); end
        checks++; if (bus.p2_lives !== 2'd2) begin errors++; $display("FAIL timeout_p2_lives: got %0d want 2", bus.p2_lives); end
        checks++; if (bus.game_over !== 1'b0) begin errors++; $display("FAIL timeout_game_over: got %0d want 0", bus.game_over); end
    endtask

    task automatic test_both_strobe();
        int c, r;
        do_reset();
        begin_game();
        bus.p1_valid = 1'b1; bus.p1_choice = exp_door;
        bus.p2_valid = 1'b1; bus.p2_choice = exp_door + 2'd1;
        tick();
        idle_inputs();
        checks++; if (bus.time_up !== 1'b1) begin errors++; $display("FAIL both_reveal_next: got %0d want 1", bus.time_up); end
        run_to_score(c, r);
        checks++; if (r != REVEAL) begin errors++; $display("FAIL both_reveal_len: got %0d want %0d", r, REVEAL); end
        tick();
        checks++; if (bus.p1_lives !== 2'd3) begin errors++; $display("FAIL both_p1_lives: got %0d want 3", bus.p1_lives); end
        checks++; if (bus.p2_lives !== 2'd2) begin errors++; $display("FAIL both_p2_lives: got %0d want 2", bus.p2_lives); end
    endtask

    // Second P1 strobe is dropped; start held high mid-round must not restart it.
    task automatic test_ignore_second();
        int c, r;
        do_reset();
        begin_game();
        bus.start = 1'b1;
        bus.p1_valid = 1'b1; bus.p1_choice = exp_door;
        tick();
        bus.p1_valid = 1'b0;
        tick();
        bus.p1_valid = 1'b1; bus.p1_choice = exp_door + 2'd1;
        tick();
        bus.p1_valid = 1'b0;
        run_to_score(c, r);
        checks++; if (c != ROUND - 3) begin errors++; $display("FAIL ignore_choose_left: got %0d want %0d", c, ROUND - 3); end
        tick();
        bus.start = 1'b0;
        checks++; if (bus.p1_lives !== 2'd3) begin errors++; $display("FAIL ignore_p1_lives: got %0d want 3", bus.p1_lives); end
        checks++; if (bus.p2_lives !== 2'd2) begin errors++; $display("FAIL ignore_p2_lives: got %0d want 2", bus.p2_lives); end
    endtask

    task automatic test_outside_choose();
        int c, r;
        do_reset();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_door = lfsr_m[1:0];
        bus.p1_valid = 1'b1; bus.p1_choice = exp_door;
        bus.p2_valid = 1'b1; bus.p2_choice = exp_door;
        tick();
        idle_inputs();
        run_to_score(c, r);
        checks++; if (c != ROUND) begin errors++; $display("FAIL outside_choose_len: got %0d want %0d", c, ROUND); end
        tick();
        checks++; if (bus.p1_lives !== 2'd2) begin errors++; $display("FAIL outside_p1_lives: got %0d want 2", bus.p1_lives); end
        checks++; if (bus.p2_lives !== 2'd2) begin errors++; $display("FAIL outside_p2_lives: got %0d want 2", bus.p2_lives); end
    endtask

    task automatic test_late_strobe();
        int c, r;
        do_reset();
        begin_game();
        repeat (ROUND - 1) tick();
        checks++; if (bus.time_up !== 1'b0) begin errors++; $display("FAIL late_still_choose: got %0d want 0", bus.time_up); end
        bus.p1_valid = 1'b1; bus.p1_choice = exp_door;
        tick();
        idle_inputs();
        checks++; if (bus.time_up !== 1'b1) begin errors++; $display("FAIL late_reveal: got %0d want 1", bus.time_up); end
        run_to_score(c, r);
        tick();
        checks++; if (bus.p1_lives !== 2'd3) begin errors++; $display("FAIL late_p1_lives: got %0d want 3", bus.p1_lives); end
        checks++; if (bus.p2_lives !== 2'd2) begin errors++; $display("FAIL late_p2_lives: got %0d want 2", bus.p2_lives); end
    endtask

    task automatic test_p2_wins();
        int c, r;
        do_reset();
        begin_game();
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus.correct_door !== exp_door) begin errors++; $display("FAIL p2win_door%0d: got %0d want %0d", k, bus.correct_door, exp_door); end
            bus.p1_valid = 1'b1; bus.p1_choice = exp_door + 2'd1;
            bus.p2_valid = 1'b1; bus.p2_choice = exp_door;
            tick();
            idle_inputs();
            run_to_score(c, r);
            tick();
            checks++; if (bus.p1_lives !== 2'(2 - k)) begin errors++; $display("FAIL p2win_p1_lives%0d: got %0d want %0d", k, bus.p1_lives, 2 - k); end
            checks++; if (bus.p2_lives !== 2'd3) begin errors++; $display("FAIL p2win_p2_lives%0d: got %0d want 3", k, bus.p2_lives); end
            if (k < 2) begin
                exp_door = lfsr_m[1:0];
                tick();
            end
        end
        checks++; if (bus.game_over !== 1'b1) begin errors++; $display("FAIL p2win_game_over: got %0d want 1", bus.game_over); end
        checks++; if (bus.winner !== 2'b10) begin errors++; $display("FAIL p2win_winner: got %0d want 2", bus.winner); end
        bus.p1_valid = 1'b1; bus.p2_valid = 1'b1;
        repeat (20) tick();
        idle_inputs();
        checks++; if (bus.p1_lives !== 2'd0) begin errors++; $display("FAIL p2win_over_p1: got %0d want 0", bus.p1_lives); end
        checks++; if (bus.p2_lives !== 2'd3) begin errors++; $display("FAIL p2win_over_p2: got %0d want 3", bus.p2_lives); end
        checks++; if (bus.game_over !== 1'b1) begin errors++; $display("FAIL p2win_over_hold: got %0d want 1", bus.game_over); end
    endtask

    task automatic test_draw();
        int c, r;
        do_reset();
        begin_game();
        for (int k = 0; k < 3; k++) begin
            bus.p1_valid = 1'b1; bus.p1_choice = exp_door + 2'd1;
            bus.p2_valid = 1'b1; bus.p2_choice = exp_door + 2'd2;
            tick();
            idle_inputs();
            run_to_score(c, r);
            tick();
            checks++; if (bus.p1_lives !== 2'(2 - k)) begin errors++; $display("FAIL draw_p1_lives%0d: got %0d want %0d", k, bus.p1_lives, 2 - k); end
            checks++; if (bus.p2_lives !== 2'(2 - k)) begin errors++; $display("FAIL draw_p2_lives%0d: got %0d want %0d", k, bus.p2_lives, 2 - k); end
            if (k < 2) begin
                exp_door = lfsr_m[1:0];
                tick();
            end
        end
        checks++; if (bus.game_over !== 1'b1) begin errors++; $display("FAIL draw_game_over: got %0d want 1", bus.game_over); end
        checks++; if (bus.winner !== 2'b11) begin errors++; $display("FAIL draw_winner: got %0d want 3", bus.winner); end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.p1_lives !== 2'd3) begin errors++; $display("FAIL restart_p1_lives: got %0d want 3", bus.p1_lives); end
        checks++; if (bus.p2_lives !== 2'd3) begin errors++; $display("FAIL restart_p2_lives: got %0d want 3", bus.p2_lives); end
        checks++; if (bus.game_over !== 1'b0) begin errors++; $display("FAIL restart_game_over: got %0d want 0", bus.game_over); end
        checks++; if (bus.winner !== 2'd0) begin errors++; $display("FAIL restart_winner: got %0d want 0", bus.winner); end
    endtask

    task automatic test_reset_reveal();
        do_reset();
        begin_game();
        bus.p1_valid = 1'b1; bus.p1_choice = exp_door + 2'd1;
        bus.p2_valid = 1'b1; bus.p2_choice = exp_door + 2'd1;
        tick();
        idle_inputs();
        tick();
        checks++; if (bus.time_up !== 1'b1) begin errors++; $display("FAIL rst_rev_in_reveal: got %0d want 1", bus.time_up); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.time_up !== 1'b0) begin errors++; $display("FAIL rst_rev_time_up: got %0d want 0", bus.time_up); end
        checks++; if (bus.correct_door !== 2'd0) begin errors++; $display("FAIL rst_rev_door: got %0d want 0", bus.correct_door); end
        tick();
        reset = 1'b0;
        repeat (12) tick();
        checks++; if (bus.time_up !== 1'b0) begin errors++; $display("FAIL rst_rev_idle: got %0d want 0", bus.time_up); end
        checks++; if (bus.p1_lives !== 2'd3) begin errors++; $display("FAIL rst_rev_p1_lives: got %0d want 3", bus.p1_lives); end
        checks++; if (bus.p2_lives !== 2'd3) begin errors++; $display("FAIL rst_rev_p2_lives: got %0d want 3", bus.p2_lives); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_timeout();
        test_both_strobe();
        test_ignore_second();
        test_outside_choose();
        test_late_strobe();
        test_p2_wins();
        test_draw();
        test_reset_reveal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 The block SHALL have parameter ROUND_CYCLES, default 250000000, the length of the choice window in clk cycles (10 s at 25 MHz).
REQ-002 The block SHALL have parameter REVEAL_CYCLES, default 75000000, the number of clk cycles the correct door is shown open.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: level-sampled request to begin or restart a game.
REQ-006 The block SHALL have port p1_valid, input, 1 bit: player 1 choice strobe.
REQ-007 The block SHALL have port p1_choice, input, 2 bits: player 1 door index 0-3.
REQ-008 The block SHALL have port p2_valid, input, 1 bit: player 2 choice strobe.
REQ-009 The block SHALL have port p2_choice, input, 2 bits: player 2 door index 0-3.
REQ-010 The block SHALL have port correct_door, output, 2 bits: door index sent to the screen drawer.
REQ-011 The block SHALL have port p1_lives, output, 2 bits: player 1 lives, 0-3.
REQ-012 The block SHALL have port p2_lives, output, 2 bits: player 2 lives, 0-3.
REQ-013 The block SHALL have port time_up, output, 1 bit: reveal phase; the drawer opens correct_door.
REQ-014 The block SHALL have port game_over, output, 1 bit: game finished.
REQ-015 The block SHALL have port winner, output, 2 bits: 00 none, 01 P1, 10 P2, 11 draw.

Function
REQ-016 All outputs SHALL be registered and change only on the rising edge of clk, except when reset is asserted.
REQ-017 An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'h01) SHALL advance every clk cycle, including in IDLE, and SHALL never reach the all-zero state.
REQ-018 The state machine SHALL have the states IDLE, PICK, CHOOSE, REVEAL, SCORE and OVER.
REQ-019 IDLE: the block SHALL wait; start=1 -> PICK.
REQ-020 PICK, 1 cycle: correct_door <= lfsr[1:0]; clear both latched choices and their latched flags; timer <= ROUND_CYCLES-1; -> CHOOSE.
REQ-021 CHOOSE: the timer SHALL decrement each cycle; on the cycle it reaches 0, or on the cycle both players have latched a choice, the block SHALL load timer <= REVEAL_CYCLES-1 and go -> REVEAL.
REQ-022 CHOOSE SHALL therefore last exactly ROUND_CYCLES cycles when fewer than two choices are latched.
REQ-023 Choice latching: in CHOOSE only, the first pxN_valid=1 cycle SHALL latch pxN_choice; later strobes from that player SHALL be ignored.
REQ-024 Choice latching: simultaneous p1_valid and p2_valid SHALL both be latched in the same cycle.
REQ-025 Choice latching: valid strobes in every state other than CHOOSE SHALL be ignored.
REQ-026 A valid strobe on the same cycle the timer expires SHALL be latched and counted in scoring.
REQ-027 REVEAL: time_up=1 for exactly REVEAL_CYCLES cycles; at timer 0 -> SCORE; time_up=0 in every other state.
REQ-028 SCORE, 1 cycle: a player SHALL lose 1 life if not latched or if the latched choice != correct_door; lives SHALL saturate at 0, never wrap.
REQ-029 SCORE: if either updated life count is 0 -> OVER, otherwise -> PICK.
REQ-030 OVER: game_over=1; winner SHALL be 01 if only P2 is at 0, 10 if only P1 is at 0, and 11 if both are at 0.
REQ-031 OVER: start=1 SHALL set lives <= 3/3, game_over <= 0, winner <= 00, and go -> PICK.
REQ-032 correct_door SHALL be held constant from PICK through SCORE.
REQ-033 start SHALL be ignored outside IDLE and OVER.
REQ-034 Timer width SHALL be $clog2(max(ROUND_CYCLES,REVEAL_CYCLES)); REQ-021 and REQ-027 SHALL hold at ROUND_CYCLES=1 and REVEAL_CYCLES=1.

Reset
REQ-035 reset=1 SHALL immediately, asynchronously, force state=IDLE, correct_door=00, p1_lives=p2_lives=11, time_up=0, game_over=0, winner=00, timer=0, choices and their latched flags cleared, and lfsr=8'h01.
REQ-036 Reset asserted mid-round, for example during REVEAL, SHALL abort the round with no life change and go to IDLE.

Verification (ROUND_CYCLES=8, REVEAL_CYCLES=4)
REQ-037 Reset, then start=1 for 1 cycle -> PICK 1 cycle; with no choices, CHOOSE lasts 8 cycles; time_up=1 for 4 cycles; then p1_lives=p2_lives=10.
REQ-038 P1 strobes correct_door and P2 strobes (correct_door+1)%4 in the same cycle -> REVEAL entered the next cycle; after SCORE p1_lives=11 and p2_lives=10.
REQ-039 P1 strobes the correct door, then strobes a wrong door 2 cycles later -> second strobe ignored; p1_lives stays 11.
REQ-040 Three rounds with P1 always wrong and P2 always right -> p1_lives 10, 01, 00; game_over=1, winner=10; a further strobe leaves lives unchanged.
REQ-041 Both players miss every round from 01/01 -> both reach 00 with no wrap, winner=11; start=1 -> lives 11/11, game_over=0.
REQ-042 reset pulsed during REVEAL -> time_up=0 in the same cycle; IDLE, lives 11/11, correct_door=00.
